// File: rtl/fetch_top_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, pc_src codes,
// the NOP encoding and the redirect decision helper.
package fetch_top_pkg;

  localparam int NB_DATA_DEFAULT = 32;
  localparam int NB_ADDR_DEFAULT = 8;

  // Next-PC source codes driven by decode.
  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_REG    = 2'b11
  } pc_src_e;

  // All-zero word doubles as the pipeline bubble.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // A redirect only flushes when it actually names a target; a
  // branch/jump flag paired with the sequential code falls through.
  function automatic logic take_redirect(input logic branch_or_jump,
                                         input logic [1:0] pc_src);
    return (branch_or_jump || (pc_src == PC_SRC_REG)) && (pc_src != PC_SRC_SEQ);
  endfunction

endpackage

// File: rtl/fetch_top_if.sv
// Bundle of the fetch-stage control, redirect, debug-load and IF/ID signals.
// master = decode / hazard / debug side, slave = fetch stage.
interface fetch_top_if #(
  parameter int NB_DATA = fetch_top_pkg::NB_DATA_DEFAULT,
  parameter int NB_ADDR = fetch_top_pkg::NB_ADDR_DEFAULT
);
  logic               enable_i;
  logic               stall_i;
  logic               pc_branch_or_jump_i;
  logic [1:0]         pc_src_i;
  logic [NB_DATA-1:0] address_branch_i;
  logic [NB_DATA-1:0] address_jump_i;
  logic [NB_DATA-1:0] address_register_i;
  logic               halt_i;
  logic               load_en_i;
  logic [NB_ADDR-1:0] load_addr_i;
  logic [NB_DATA-1:0] load_data_i;
  logic [NB_DATA-1:0] instruction_o;
  logic [NB_DATA-1:0] pc_decode_o;
  logic [NB_DATA-1:0] pc_o;
  logic               halted_o;

  modport master (
    output enable_i, stall_i, pc_branch_or_jump_i, pc_src_i,
           address_branch_i, address_jump_i, address_register_i,
           halt_i, load_en_i, load_addr_i, load_data_i,
    input  instruction_o, pc_decode_o, pc_o, halted_o
  );

  modport slave (
    input  enable_i, stall_i, pc_branch_or_jump_i, pc_src_i,
           address_branch_i, address_jump_i, address_register_i,
           halt_i, load_en_i, load_addr_i, load_data_i,
    output instruction_o, pc_decode_o, pc_o, halted_o
  );
endinterface

// File: rtl/fetch_top_instruction_memory.sv
// Instruction memory: asynchronous read for same-cycle fetch, synchronous
// write for the debug loader. Contents are intentionally not reset.
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clock_i,
  input  logic               write_en,
  input  logic [NB_ADDR-1:0] write_addr,
  input  logic [NB_DATA-1:0] write_data,
  input  logic [NB_ADDR-1:0] read_addr,
  output logic [NB_DATA-1:0] read_data
);

  logic [NB_DATA-1:0] mem_r [2**NB_ADDR];

  // Debug write port; a same-address read this cycle still sees the old word.
  always_ff @(posedge clock_i) begin
    if (write_en) begin
      mem_r[write_addr] <= write_data;
    end
  end

  assign read_data = mem_r[read_addr];

endmodule

// File: rtl/fetch_top.sv
// Instruction-fetch stage: PC register, next-PC selection, instruction
// memory and the IF/ID register feeding decode, plus the sticky halt flag.
module fetch_top
  import fetch_top_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int NB_ADDR = NB_ADDR_DEFAULT
) (
  input  logic      clock_i,
  input  logic      reset_i,
  fetch_top_if.slave bus
);

  logic [NB_DATA-1:0] pc_r;
  logic [NB_DATA-1:0] instruction_r;
  logic [NB_DATA-1:0] pc_decode_r;
  logic               halted_r;

  logic               redirect_s;
  logic [NB_DATA-1:0] target_s;
  logic [NB_DATA-1:0] pc_plus_one_s;
  logic [NB_DATA-1:0] fetched_s;
  logic               load_we_s;

  assign pc_plus_one_s = pc_r + NB_DATA'(1'b1);

  // Memory is only writable while the core is frozen.
  assign load_we_s = bus.load_en_i && !bus.enable_i;

  instruction_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .clock_i    (clock_i),
    .write_en   (load_we_s),
    .write_addr (bus.load_addr_i),
    .write_data (bus.load_data_i),
    .read_addr  (pc_r[NB_ADDR-1:0]),
    .read_data  (fetched_s)
  );

  // Redirect decision and target selection from decode's pc_src code.
  always_comb begin
    redirect_s = take_redirect(bus.pc_branch_or_jump_i, bus.pc_src_i);
    target_s   = pc_plus_one_s;
    case (bus.pc_src_i)
      PC_SRC_BRANCH: target_s = bus.address_branch_i;
      PC_SRC_JUMP:   target_s = bus.address_jump_i;
      PC_SRC_REG:    target_s = bus.address_register_i;
      default:       target_s = pc_plus_one_s;
    endcase
  end

  // PC, IF/ID and halt flag, in priority: freeze > halted > halt > stall > redirect > seq.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_r          <= '0;
      instruction_r <= NB_DATA'(NOP);
      pc_decode_r   <= '0;
      halted_r      <= 1'b0;
    end else if (!bus.enable_i) begin
      pc_r          <= pc_r;
      instruction_r <= instruction_r;
      pc_decode_r   <= pc_decode_r;
      halted_r      <= halted_r;
    end else if (halted_r || bus.halt_i) begin
      instruction_r <= NB_DATA'(NOP);
      pc_decode_r   <= '0;
      halted_r      <= 1'b1;
    end else if (bus.stall_i) begin
      pc_r          <= pc_r;
      instruction_r <= instruction_r;
      pc_decode_r   <= pc_decode_r;
    end else if (redirect_s) begin
      pc_r          <= target_s;
      instruction_r <= NB_DATA'(NOP);
      pc_decode_r   <= '0;
    end else begin
      pc_r          <= pc_plus_one_s;
      instruction_r <= fetched_s;
      pc_decode_r   <= pc_plus_one_s;
    end
  end

  assign bus.pc_o          = pc_r;
  assign bus.instruction_o = instruction_r;
  assign bus.pc_decode_o   = pc_decode_r;
  assign bus.halted_o      = halted_r;

endmodule

// File: tb/tb_fetch_top.sv
// Bench for fetch_top: directed scenarios followed by a randomized phase,
// all compared against a behavioural model of the fetch stage.
module tb_fetch_top;

  logic clock_i = 1'b0;
  logic reset_i;

  fetch_top_if #(.NB_DATA(32), .NB_ADDR(8)) bus ();

  fetch_top #(.NB_DATA(32), .NB_ADDR(8)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  // Behavioural model state.
  logic [31:0] mem_m [256];
  logic [31:0] pc_m;
  logic [31:0] instr_m;
  logic [31:0] pcdec_m;
  logic        halted_m;

  int n_total = 0;
  int n_pass  = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    expect_eq({tag, ".instruction"}, bus.instruction_o, instr_m);
    expect_eq({tag, ".pc_decode"}, bus.pc_decode_o, pcdec_m);
    expect_eq({tag, ".pc"}, bus.pc_o, pc_m);
    expect_eq({tag, ".halted"}, {31'd0, bus.halted_o}, {31'd0, halted_m});
  endtask

  task automatic model_reset();
    pc_m     = 32'd0;
    instr_m  = 32'd0;
    pcdec_m  = 32'd0;
    halted_m = 1'b0;
  endtask

  // One clock edge of the fetch stage, evaluated from the current inputs.
  task automatic model_edge();
    if (!bus.enable_i) begin
      if (bus.load_en_i) mem_m[bus.load_addr_i] = bus.load_data_i;
    end else if (halted_m) begin
      instr_m = 32'd0;
      pcdec_m = 32'd0;
    end else if (bus.halt_i) begin
      halted_m = 1'b1;
      instr_m  = 32'd0;
      pcdec_m  = 32'd0;
    end else if (bus.stall_i) begin
      // everything holds
    end else if (bus.pc_src_i != 2'd0 && (bus.pc_branch_or_jump_i || bus.pc_src_i == 2'd3)) begin
      if (bus.pc_src_i == 2'd1)      pc_m = bus.address_branch_i;
      else if (bus.pc_src_i == 2'd2) pc_m = bus.address_jump_i;
      else                           pc_m = bus.address_register_i;
      instr_m = 32'd0;
      pcdec_m = 32'd0;
    end else begin
      instr_m = mem_m[pc_m % 256];
      pcdec_m = pc_m + 32'd1;
      pc_m    = pc_m + 32'd1;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clock_i);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.enable_i            = 1'b1;
    bus.stall_i             = 1'b0;
    bus.pc_branch_or_jump_i = 1'b0;
    bus.pc_src_i            = 2'b00;
    bus.address_branch_i    = 32'd0;
    bus.address_jump_i      = 32'd0;
    bus.address_register_i  = 32'd0;
    bus.halt_i              = 1'b0;
    bus.load_en_i           = 1'b0;
    bus.load_addr_i         = 8'd0;
    bus.load_data_i         = 32'd0;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    bus.enable_i    = 1'b0;
    bus.load_en_i   = 1'b1;
    bus.load_addr_i = addr;
    bus.load_data_i = data;
    tick("preload");
  endtask

  initial begin
    // Reset state.
    idle_inputs();
    reset_i = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;

    // Fill the whole memory, then place the directed program words.
    for (int i = 0; i < 256; i++) load_word(8'(i), $urandom);
    load_word(8'h00, 32'hA000_000A);
    load_word(8'h01, 32'hB000_000B);
    load_word(8'h02, 32'hC000_000C);
    load_word(8'h03, 32'hD000_000D);

    // Sequential fetch A, B.
    idle_inputs();
    tick("seq_a");
    expect_eq("seq_a.const", bus.instruction_o, 32'hA000_000A);
    expect_eq("seq_a.pcdec_const", bus.pc_decode_o, 32'd1);
    tick("seq_b");

    // Two-cycle stall while B is in IF/ID.
    bus.stall_i = 1'b1;
    tick("stall1");
    tick("stall2");
    expect_eq("stall.b_held", bus.instruction_o, 32'hB000_000B);
    expect_eq("stall.pc_held", bus.pc_o, 32'd2);
    bus.stall_i = 1'b0;
    tick("seq_c");
    expect_eq("seq_c.const", bus.instruction_o, 32'hC000_000C);
    tick("seq_d");
    expect_eq("seq_d.pcdec_const", bus.pc_decode_o, 32'd4);

    // Taken branch to 0x10: flush then fetch.
    bus.pc_branch_or_jump_i = 1'b1;
    bus.pc_src_i            = 2'b01;
    bus.address_branch_i    = 32'h10;
    tick("branch_flush");
    expect_eq("branch.pc_const", bus.pc_o, 32'h10);
    expect_eq("branch.nop_const", bus.instruction_o, 32'd0);
    idle_inputs();
    tick("branch_target");

    // Branch flag with sequential code behaves as sequential.
    bus.pc_branch_or_jump_i = 1'b1;
    bus.pc_src_i            = 2'b00;
    bus.address_branch_i    = 32'h77;
    tick("redirect_seq");
    idle_inputs();

    // Stall masks a jump; jump taken once the stall drops.
    bus.stall_i             = 1'b1;
    bus.pc_branch_or_jump_i = 1'b1;
    bus.pc_src_i            = 2'b10;
    bus.address_jump_i      = 32'h20;
    tick("stall_jump_hold");
    bus.stall_i = 1'b0;
    tick("jump_flush");
    expect_eq("jump.pc_const", bus.pc_o, 32'h20);
    idle_inputs();
    tick("jump_target");

    // Register target 0x1FF: memory index wraps from 0xFF to 0x00.
    bus.pc_src_i           = 2'b11;
    bus.address_register_i = 32'h1FF;
    tick("jr_flush");
    expect_eq("jr.pc_const", bus.pc_o, 32'h1FF);
    idle_inputs();
    tick("wrap_ff");
    tick("wrap_00");
    expect_eq("wrap.instr_const", bus.instruction_o, 32'hA000_000A);
    expect_eq("wrap.pcdec_const", bus.pc_decode_o, 32'h201);

    // Randomized traffic, no halt; loads kept away from the low words.
    for (int i = 0; i < 400; i++) begin
      bus.enable_i            = ($urandom_range(0, 7) != 0);
      bus.stall_i             = ($urandom_range(0, 4) == 0);
      bus.pc_branch_or_jump_i = ($urandom_range(0, 3) == 0);
      bus.pc_src_i            = 2'($urandom_range(0, 3));
      bus.address_branch_i    = $urandom;
      bus.address_jump_i      = $urandom;
      bus.address_register_i  = $urandom;
      bus.load_en_i           = $urandom_range(0, 1) == 1;
      bus.load_addr_i         = 8'($urandom_range(64, 254));
      bus.load_data_i         = $urandom;
      tick("random");
    end

    // Halt: sticky flag, NOPs flow, PC holds; loads with enable=1 are dropped.
    idle_inputs();
    bus.halt_i = 1'b1;
    tick("halt_set");
    expect_eq("halt.flag_const", {31'd0, bus.halted_o}, 32'd1);
    bus.halt_i      = 1'b0;
    bus.load_en_i   = 1'b1;
    bus.load_addr_i = 8'h00;
    bus.load_data_i = 32'hDEAD_BEEF;
    tick("halted_nop1");
    tick("halted_nop2");
    bus.enable_i  = 1'b0;
    bus.load_en_i = 1'b0;
    tick("halted_frozen");

    // Asynchronous reset between edges.
    @(posedge clock_i);
    #3;
    reset_i = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    reset_i = 1'b1;
    idle_inputs();
    tick("post_reset_fetch");
    expect_eq("load_rejected", bus.instruction_o, 32'hA000_000A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
